mips_div_sequencer: RTL and testbench
=====================================

Name: mips_div_sequencer

Overview:
- Multi-cycle divide controller for the MIPS core; executes DIV/DIVU for Remainder-class programs.
- Sequences a restoring shift-subtract datapath and owns the HI/LO result registers.
- Stalls the ProgCounter while a divide is in flight, so a following MFHI/MFLO reads final values.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  decode asserts for one cycle when DIV/DIVU is issued.
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start.
- rs_val  in  WIDTH  dividend from RF read port A; sampled with start.
- rt_val  in  WIDTH  divisor from RF read port B; sampled with start.
- stall  out  1  freezes ProgCounter/IF while high.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when HI/LO have been updated.
- div_zero  out  1  sticky flag: last completed divide had divisor 0.
- hi  out  WIDTH  remainder register.
- lo  out  WIDTH  quotient register.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset, including mid-operation: state=IDLE, stall=0, busy=0, done=0, div_zero=0, hi=0, lo=0, iteration counter=0. Any in-flight divide is abandoned.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - If start=1, latch operands and is_signed, then go to PREP.
  - start=0: remain in IDLE.
- PREP (1 cycle):
  - Form magnitudes: if is_signed, take |x| as an unsigned WIDTH-bit value; otherwise pass x through. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned.
  - Record q_neg = sign(rs) XOR sign(rt) and r_neg = sign(rs), both only when signed.
  - If rt_val == 0, go to DONE with hi = rs_val (raw), lo = all ones, and div_zero=1.
  - Otherwise clear the partial remainder, load the counter with WIDTH−1, and go to ITER.
- ITER (exactly WIDTH cycles), each cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract using a WIDTH+1-bit difference; if non-negative, keep the difference and set quo[0]=1.
  - When counter==0, go to FIX; otherwise decrement the counter.
- FIX (1 cycle):
  - lo = q_neg ? −quo : quo; hi = r_neg ? −rem : rem (two's complement, truncated to WIDTH).
  - div_zero=0; go to DONE.
- DONE (1 cycle):
  - done=1, and hi/lo are already valid this cycle.
  - If start=1, accept the new divide (go to PREP); else go to IDLE.
- Latency: start sampled at edge k.
  - Normal divide: done is high in cycle k+WIDTH+3.
  - Divide by zero: done is high in cycle k+2.
- stall = 1 in PREP, ITER and FIX; 0 in IDLE and DONE. This lets the instruction after DIV issue in the DONE cycle and read new HI/LO.
- start while state is PREP, ITER or FIX is ignored; the current operation is unaffected.
- hi/lo change only on the FIX→DONE or PREP→DONE (zero) transitions; otherwise they hold.
- Overflow case, signed −2^(WIDTH−1) / −1: lo = 0x80000000, hi = 0. No flag or trap.
- Remainder sign always follows the dividend (MIPS semantics); quotient truncates toward zero.

Test Plan:
- DIVU 17/5: start pulse → stall high 34 cycles; done in cycle k+35; lo=0x00000003, hi=0x00000002, div_zero=0.
- DIV −17/5 (0xFFFFFFEF, 0x5): lo=0xFFFFFFFD, hi=0xFFFFFFFE. DIV 17/−5: lo=0xFFFFFFFD, hi=0x00000002.
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0x00000000. DIVU 0xFFFFFFFF/0x10: lo=0x0FFFFFFF, hi=0xF.
- DIVU 100/0: done in cycle k+2; hi=0x64, lo=0xFFFFFFFF, div_zero=1. A following DIVU 9/3 clears div_zero; lo=3, hi=0.
- Second start pulsed mid-ITER with other operands → ignored; results match the first divide. start asserted in the DONE cycle → accepted; second result follows after WIDTH+3 cycles.
- rst asserted during ITER cycle 10 → next cycle: IDLE, stall=0, hi=lo=0, done never pulses. A fresh divide then completes correctly.

Source files
------------

// File: rtl/mips_div_sequencer.sv
// Multi-cycle DIV/DIVU controller for the MIPS core.
// Runs a restoring shift-subtract divide over WIDTH iterations and owns HI/LO.
// It holds the pipeline stalled until HI/LO carry the final result.
module mips_div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic             sgn_q;
   logic             qneg_q;
   logic             rneg_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             dz_q;
   logic             stall_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] dvd_mag_d;
   logic [WIDTH-1:0] dvs_mag_d;
   logic [WIDTH:0]   shift_d;
   logic [WIDTH:0]   diff_d;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;

   // Operand magnitudes and one restoring iteration step.
   // The trial difference is WIDTH+1 bits: the shifted remainder is below
   // twice the divisor, so the top bit of the difference is its sign.
   always_comb begin
      dvd_mag_d = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
      dvs_mag_d = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
      shift_d   = {rem_q, quo_q[WIDTH-1]};
      diff_d    = shift_d - {1'b0, dvs_q};
      if (!diff_d[WIDTH]) begin
         rem_d = diff_d[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_d = shift_d[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Divide FSM with registered status outputs and HI/LO ownership.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
         stall_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  dvd_q   <= rs_val;
                  dvs_q   <= rt_val;
                  sgn_q   <= is_signed;
                  state_q <= S_PREP;
                  stall_q <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  stall_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            S_PREP: begin
               if (dvs_q == '0) begin
                  // Divide by zero: raw dividend to HI, all ones to LO.
                  hi_q    <= dvd_q;
                  lo_q    <= '1;
                  dz_q    <= 1'b1;
                  done_q  <= 1'b1;
                  stall_q <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  quo_q   <= dvd_mag_d;
                  dvs_q   <= dvs_mag_d;
                  rem_q   <= '0;
                  qneg_q  <= sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                  rneg_q  <= sgn_q & dvd_q[WIDTH-1];
                  cnt_q   <= CW'(WIDTH - 1);
                  state_q <= S_ITER;
               end
            end
            S_ITER: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (cnt_q == '0) begin
                  state_q <= S_FIX;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_FIX: begin
               // Quotient truncates toward zero; remainder follows the dividend.
               lo_q    <= qneg_q ? -quo_q : quo_q;
               hi_q    <= rneg_q ? -rem_q : rem_q;
               dz_q    <= 1'b0;
               done_q  <= 1'b1;
               stall_q <= 1'b0;
               state_q <= S_DONE;
            end
            default: begin
               state_q <= S_IDLE;
               stall_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign stall    = stall_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mips_div_sequencer.sv
// Directed bench for mips_div_sequencer (WIDTH=32).
module tb_mips_div_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        stall;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mips_div_sequencer #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .is_signed(is_signed),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled on the following posedge.
   task automatic pulse(input logic sg, input logic [31:0] a, input logic [31:0] b);
      start     = 1'b1;
      is_signed = sg;
      rs_val    = a;
      rt_val    = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Follows one divide from cycle k+1 to the done pulse; optionally injects
   // a stray start (5/0 signed) at cycle inj_at of the operation.
   task automatic wait_done(input string tag, input int exp_lat, input int exp_stall,
                            input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                            input logic exp_dz, input int inj_at);
      int          n = 0;
      int          st = 0;
      logic        hold_ok = 1'b1;
      logic        seen = 1'b0;
      logic [31:0] hi0 = hi;
      logic [31:0] lo0 = lo;
      while (!seen && n < 100) begin
         @(negedge clk);
         n++;
         if (inj_at == n) begin
            start = 1'b1; is_signed = 1'b1; rs_val = 32'd5; rt_val = 32'd0;
         end else if (inj_at + 1 == n) begin
            start = 1'b0;
         end
         if (done) seen = 1'b1;
         else begin
            if (stall) st++;
            if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
         end
      end
      start = 1'b0;
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_stall_cycles"}, st, exp_stall);
      chk({tag, "_hilo_hold"}, {31'd0, hold_ok}, 32'd1);
      chk({tag, "_lo"}, lo, exp_lo);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
      chk({tag, "_stall_at_done"}, {31'd0, stall}, 32'd0);
      chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
   endtask

   initial begin
      int   cyc;
      logic done_seen;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; rs_val = '0; rt_val = '0;
      repeat (3) @(negedge clk);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      pulse(1'b0, 32'd17, 32'd5);
      wait_done("divu_17_5", 35, 34, 32'h00000003, 32'h00000002, 1'b0, 0);
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);

      pulse(1'b1, 32'hFFFFFFEF, 32'h00000005);
      wait_done("div_m17_5", 35, 34, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, 0);
      @(negedge clk);
      pulse(1'b1, 32'd17, 32'hFFFFFFFB);
      wait_done("div_17_m5", 35, 34, 32'hFFFFFFFD, 32'h00000002, 1'b0, 0);
      @(negedge clk);
      pulse(1'b1, 32'h80000000, 32'hFFFFFFFF);
      wait_done("div_ovf", 35, 34, 32'h80000000, 32'h00000000, 1'b0, 0);
      @(negedge clk);
      pulse(1'b0, 32'hFFFFFFFF, 32'h00000010);
      wait_done("divu_max_16", 35, 34, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 0);
      @(negedge clk);
      pulse(1'b0, 32'hFFFFFFFF, 32'h80000001);
      wait_done("divu_big_dvs", 35, 34, 32'h00000001, 32'h7FFFFFFE, 1'b0, 0);
      @(negedge clk);

      pulse(1'b0, 32'd100, 32'd0);
      wait_done("divu_by_zero", 2, 1, 32'hFFFFFFFF, 32'h00000064, 1'b1, 0);
      @(negedge clk);
      chk("dz_sticky_idle", {31'd0, div_zero}, 32'd1);
      pulse(1'b0, 32'd9, 32'd3);
      wait_done("divu_9_3", 35, 34, 32'h00000003, 32'h00000000, 1'b0, 0);
      @(negedge clk);

      // Stray start mid-ITER is ignored; start in DONE is accepted.
      pulse(1'b0, 32'd1000, 32'd7);
      wait_done("ignore_mid_iter", 35, 34, 32'd142, 32'd6, 1'b0, 10);
      pulse(1'b1, 32'hFFFFFF9C, 32'd7);
      wait_done("start_in_done", 35, 34, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 0);
      @(negedge clk);

      // Reset during ITER cycle 10 abandons the divide.
      pulse(1'b0, 32'd1000, 32'd7);
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_stall", {31'd0, stall}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      done_seen = 1'b0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      chk("midrst_no_done", {31'd0, done_seen}, 32'd0);
      chk("midrst_busy_after", {31'd0, busy}, 32'd0);

      pulse(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE);
      wait_done("div_m7_m2", 35, 34, 32'h00000003, 32'hFFFFFFFF, 1'b0, 0);
      @(negedge clk);
      chk("final_idle_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
